// File: rtl/reg_file.sv
`timescale 1ns/1ps
// Architectural register file with rename tags; consumes the ROB commit port and feeds the issuer.
// Reads are combinational with zero latency; commit, rename and flush land on the next clk edge.
// rdy low holds all state; there is no other backpressure, and reads stay live while holding.
module reg_file #(
  parameter int REG_COUNT    = 32,
  parameter int REG_ID_WIDTH = 5,
  parameter int XLEN         = 32,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    reset_from_rob_bus,
  input  logic                    valid_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rd_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rs1_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rs2_from_issuer,
  output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
  output logic [XLEN-1:0]         vj_to_issuer,
  output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
  output logic [XLEN-1:0]         vk_to_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
  input  logic [REG_ID_WIDTH-1:0] rd_from_rob,
  input  logic [XLEN-1:0]         value_from_rob
);

  logic [XLEN-1:0]         value_q [REG_COUNT];
  logic [XLEN-1:0]         value_d [REG_COUNT];
  logic [ROB_ID_WIDTH-1:0] tag_q   [REG_COUNT];
  logic [ROB_ID_WIDTH-1:0] tag_d   [REG_COUNT];

  logic commit_vld;
  logic rename_vld;

  // x0 is never a commit or rename target, so its slot stays zero forever.
  assign commit_vld = (dest_from_rob != '0) && (rd_from_rob != '0);
  assign rename_vld = valid_from_issuer && !reset_from_rob_bus && (rd_from_issuer != '0);

  // rs1 read port: a commit retiring the tag we would hand out is forwarded as a ready value.
  always_comb begin
    qj_to_issuer = '0;
    vj_to_issuer = '0;
    if (rs1_from_issuer != '0) begin
      if ((dest_from_rob != '0) && (rd_from_rob == rs1_from_issuer) &&
          (tag_q[rs1_from_issuer] == dest_from_rob)) begin
        vj_to_issuer = value_from_rob;
      end else begin
        qj_to_issuer = tag_q[rs1_from_issuer];
        vj_to_issuer = value_q[rs1_from_issuer];
      end
    end
  end

  // rs2 read port, same rules as rs1.
  always_comb begin
    qk_to_issuer = '0;
    vk_to_issuer = '0;
    if (rs2_from_issuer != '0) begin
      if ((dest_from_rob != '0) && (rd_from_rob == rs2_from_issuer) &&
          (tag_q[rs2_from_issuer] == dest_from_rob)) begin
        vk_to_issuer = value_from_rob;
      end else begin
        qk_to_issuer = tag_q[rs2_from_issuer];
        vk_to_issuer = value_q[rs2_from_issuer];
      end
    end
  end

  // Next state: commit writes the value unconditionally but only retires a matching tag;
  // a flush wipes every tag afterwards, otherwise a rename overrides the same-cycle clear.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    if (rdy) begin
      if (commit_vld) begin
        value_d[rd_from_rob] = value_from_rob;
        if (tag_q[rd_from_rob] == dest_from_rob) begin
          tag_d[rd_from_rob] = '0;
        end
      end
      if (reset_from_rob_bus) begin
        tag_d = '{default: '0};
      end else if (rename_vld) begin
        tag_d[rd_from_issuer] = dest_from_issuer;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '{default: '0};
      tag_q   <= '{default: '0};
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

  // ROB id 0 means "no tag", so renaming to it would silently mark the register ready.
  ap_no_zero_dest: assert property (@(posedge clk) disable iff (!rst)
    valid_from_issuer |-> (dest_from_issuer != '0));

endmodule

// File: tb/tb_reg_file.sv
`timescale 1ns/1ps
// Self-checking bench for reg_file: directed vector table, hand-written async reset
// sequence, and randomized traffic checked against an array-based reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rfl;
  logic        vld;
  logic [4:0]  rd_i;
  logic [3:0]  dest_i;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [3:0]  qj;
  logic [31:0] vj;
  logic [3:0]  qk;
  logic [31:0] vk;
  logic [3:0]  dest_r;
  logic [4:0]  rd_r;
  logic [31:0] val_r;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural values and pending tags.
  logic [31:0] m_val [32];
  logic [3:0]  m_tag [32];

  always #5 clk = ~clk;

  reg_file dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .reset_from_rob_bus (rfl),
    .valid_from_issuer  (vld),
    .rd_from_issuer     (rd_i),
    .dest_from_issuer   (dest_i),
    .rs1_from_issuer    (rs1),
    .rs2_from_issuer    (rs2),
    .qj_to_issuer       (qj),
    .vj_to_issuer       (vj),
    .qk_to_issuer       (qk),
    .vk_to_issuer       (vk),
    .dest_from_rob      (dest_r),
    .rd_from_rob        (rd_r),
    .value_from_rob     (val_r)
  );

  typedef struct {
    logic        rdy, fl, vld;
    logic [4:0]  rd_i;
    logic [3:0]  dest_i;
    logic [4:0]  rs1, rs2;
    logic [3:0]  dest_r;
    logic [4:0]  rd_r;
    logic [31:0] val_r;
    logic [3:0]  qj;
    logic [31:0] vj;
    logic [3:0]  qk;
    logic [31:0] vk;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  function automatic vec_t mk(input logic a_rdy, input logic a_fl, input logic a_vld,
                              input logic [4:0] a_rd_i, input logic [3:0] a_dest_i,
                              input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                              input logic [3:0] a_dest_r, input logic [4:0] a_rd_r,
                              input logic [31:0] a_val_r,
                              input logic [3:0] e_qj, input logic [31:0] e_vj,
                              input logic [3:0] e_qk, input logic [31:0] e_vk);
    vec_t v;
    v.rdy = a_rdy; v.fl = a_fl; v.vld = a_vld; v.rd_i = a_rd_i; v.dest_i = a_dest_i;
    v.rs1 = a_rs1; v.rs2 = a_rs2; v.dest_r = a_dest_r; v.rd_r = a_rd_r; v.val_r = a_val_r;
    v.qj = e_qj; v.vj = e_vj; v.qk = e_qk; v.vk = e_vk;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    rdy = 1'b1; rfl = 1'b0; vld = 1'b0; rd_i = '0; dest_i = 4'd1;
    rs1 = '0; rs2 = '0; dest_r = '0; rd_r = '0; val_r = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0;
      m_tag[i] = '0;
    end
  endtask

  // Expected read for one source register given the current commit-port inputs.
  task automatic model_read(input logic [4:0] s, output logic [3:0] q, output logic [31:0] v);
    q = '0;
    v = '0;
    if (s != 0) begin
      if (dest_r != 0 && rd_r == s && m_tag[s] == dest_r) begin
        v = val_r;
      end else begin
        q = m_tag[s];
        v = m_val[s];
      end
    end
  endtask

  // Apply the effect of the clock edge with the currently driven inputs.
  task automatic model_step();
    if (rdy) begin
      if (dest_r != 0 && rd_r != 0) begin
        m_val[rd_r] = val_r;
        if (m_tag[rd_r] == dest_r) m_tag[rd_r] = '0;
      end
      if (rfl) begin
        for (int i = 0; i < 32; i++) m_tag[i] = '0;
      end else if (vld && rd_i != 0) begin
        m_tag[rd_i] = dest_i;
      end
    end
  endtask

  task automatic check_vs_model(input string tag);
    logic [3:0]  eq;
    logic [31:0] ev;
    model_read(rs1, eq, ev);
    check({tag, " qj"}, 32'(qj), 32'(eq));
    check({tag, " vj"}, vj, ev);
    model_read(rs2, eq, ev);
    check({tag, " qk"}, 32'(qk), 32'(eq));
    check({tag, " vk"}, vk, ev);
  endtask

  task automatic random_cycles(input int n, input string tag);
    logic [4:0] r;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rdy    = ($urandom_range(9) != 0);
      rfl    = ($urandom_range(19) == 0);
      vld    = 1'($urandom_range(1));
      dest_i = 4'($urandom_range(15, 1));
      rd_i   = 5'($urandom_range(31));
      rs1    = 5'($urandom_range(31));
      rs2    = 5'($urandom_range(31));
      r      = 5'($urandom_range(31));
      if ($urandom_range(1) == 1 && m_tag[r] != 0) begin
        dest_r = m_tag[r];
        rd_r   = r;
      end else begin
        dest_r = 4'($urandom_range(15));
        rd_r   = 5'($urandom_range(31));
      end
      if ($urandom_range(2) == 0) rs1 = rd_r;
      if ($urandom_range(3) == 0) rs2 = rd_r;
      val_r = $urandom;
      #1;
      check_vs_model($sformatf("%s%0d", tag, c));
      model_step();
    end
  endtask

  initial begin
    // rdy fl vld rd_i dest_i rs1 rs2 dest_r rd_r val_r | qj vj qk vk
    vt[0]  = mk(1, 0, 1, 5, 3, 5, 0, 0, 0, 32'h0,     0, 32'h0,    0, 32'h0);
    vt[1]  = mk(1, 0, 0, 0, 1, 5, 0, 0, 0, 32'h0,     3, 32'h0,    0, 32'h0);
    vt[2]  = mk(1, 0, 0, 0, 1, 5, 0, 3, 5, 32'h1234,  0, 32'h1234, 0, 32'h0);
    vt[3]  = mk(1, 0, 0, 0, 1, 5, 0, 0, 0, 32'h0,     0, 32'h1234, 0, 32'h0);
    vt[4]  = mk(1, 0, 1, 7, 2, 0, 7, 0, 0, 32'h0,     0, 32'h0,    0, 32'h0);
    vt[5]  = mk(1, 0, 1, 7, 4, 0, 7, 0, 0, 32'h0,     0, 32'h0,    2, 32'h0);
    vt[6]  = mk(1, 0, 0, 0, 1, 0, 7, 2, 7, 32'hAA,    0, 32'h0,    4, 32'h0);
    vt[7]  = mk(1, 0, 0, 0, 1, 0, 7, 0, 0, 32'h0,     0, 32'h0,    4, 32'hAA);
    vt[8]  = mk(1, 0, 1, 9, 1, 9, 0, 6, 9, 32'h55,    0, 32'h0,    0, 32'h0);
    vt[9]  = mk(1, 0, 0, 0, 1, 9, 9, 0, 0, 32'h0,     1, 32'h55,   1, 32'h55);
    vt[10] = mk(1, 0, 1, 1, 2, 1, 0, 0, 0, 32'h0,     0, 32'h0,    0, 32'h0);
    vt[11] = mk(1, 0, 1, 2, 3, 1, 2, 0, 0, 32'h0,     2, 32'h0,    0, 32'h0);
    vt[12] = mk(1, 1, 1, 3, 5, 1, 3, 2, 1, 32'h10,    0, 32'h10,   0, 32'h0);
    vt[13] = mk(1, 0, 0, 0, 1, 2, 3, 0, 0, 32'h0,     0, 32'h0,    0, 32'h0);
    vt[14] = mk(1, 0, 0, 0, 1, 1, 7, 0, 0, 32'h0,     0, 32'h10,   0, 32'hAA);
    vt[15] = mk(1, 0, 0, 0, 1, 9, 5, 0, 0, 32'h0,     0, 32'h55,   0, 32'h1234);
    vt[16] = mk(1, 0, 1, 0, 3, 0, 0, 3, 0, 32'hFF,    0, 32'h0,    0, 32'h0);
    vt[17] = mk(1, 0, 0, 0, 1, 0, 5, 0, 0, 32'h0,     0, 32'h0,    0, 32'h1234);
    vt[18] = mk(0, 0, 1, 5, 6, 5, 0, 7, 5, 32'h99,    0, 32'h1234, 0, 32'h0);
    vt[19] = mk(1, 0, 0, 0, 1, 5, 0, 0, 0, 32'h0,     0, 32'h1234, 0, 32'h0);
    vt[20] = mk(1, 0, 1, 4, 5, 4, 0, 0, 0, 32'h0,     0, 32'h0,    0, 32'h0);
    vt[21] = mk(0, 0, 0, 0, 1, 4, 0, 5, 4, 32'h77,    0, 32'h77,   0, 32'h0);
    vt[22] = mk(1, 0, 0, 0, 1, 4, 0, 0, 0, 32'h0,     5, 32'h0,    0, 32'h0);

    rst = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rs1 = 5'd5;
    rs2 = 5'd9;
    #1;
    check("reset qj", 32'(qj), 32'h0);
    check("reset vj", vj, 32'h0);
    check("reset qk", 32'(qk), 32'h0);
    check("reset vk", vk, 32'h0);
    rst = 1'b1;

    // Directed vectors; the model tracks them so random traffic continues from a known state.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rdy = vt[i].rdy; rfl = vt[i].fl; vld = vt[i].vld; rd_i = vt[i].rd_i;
      dest_i = vt[i].dest_i; rs1 = vt[i].rs1; rs2 = vt[i].rs2;
      dest_r = vt[i].dest_r; rd_r = vt[i].rd_r; val_r = vt[i].val_r;
      #1;
      check($sformatf("vec%0d qj", i), 32'(qj), 32'(vt[i].qj));
      check($sformatf("vec%0d vj", i), vj, vt[i].vj);
      check($sformatf("vec%0d qk", i), 32'(qk), 32'(vt[i].qk));
      check($sformatf("vec%0d vk", i), vk, vt[i].vk);
      model_step();
    end

    random_cycles(400, "rnd");

    // Make sure some state is loaded, then drop reset between clock edges.
    @(negedge clk);
    drive_idle();
    rd_r = 5'd12; dest_r = 4'd9; val_r = 32'hDEAD_BEEF;
    vld = 1'b1; rd_i = 5'd13; dest_i = 4'd7;
    model_step();
    @(negedge clk);
    drive_idle();
    rs1 = 5'd12;
    rs2 = 5'd13;
    #1;
    check("preload vj", vj, 32'hDEAD_BEEF);
    check("preload qk", 32'(qk), 32'h7);
    #1;
    rst = 1'b0;
    #1;
    check("async qj", 32'(qj), 32'h0);
    check("async vj", vj, 32'h0);
    check("async qk", 32'(qk), 32'h0);
    check("async vk", vk, 32'h0);
    model_reset();
    for (int r = 1; r < 32; r += 3) begin
      rs1 = 5'(r);
      rs2 = 5'(31 - r);
      #1;
      check_vs_model($sformatf("inrst%0d", r));
    end
    @(negedge clk);
    rst = 1'b1;

    random_cycles(100, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
